// File: rtl/stopwatch_pkg.sv
// Shared stopwatch definitions: FSM state encoding and counter limits
// used by both the seconds stage and the minutes counter.
package stopwatch_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      RUNNING = 2'b01,
      PAUSED  = 2'b10
   } state_t;

   localparam int SEC_MAX          = 59;
   localparam int MIN_MAX          = 99;
   localparam int TICK_DIV_DEFAULT = 100_000_000;

endpackage

// File: rtl/stopwatch_seconds_ctrl_if.sv
// Button inputs and minutes-counter handshake of the seconds stage.
interface stopwatch_seconds_ctrl_if;

   logic       start;
   logic       stop;
   logic       reset;
   logic [5:0] seconds;
   logic       min_enable;
   logic       min_reset;
   logic       running;
   logic [1:0] state;

   modport master (
      output start, stop, reset,
      input  seconds, min_enable, min_reset, running, state
   );

   modport slave (
      input  start, stop, reset,
      output seconds, min_enable, min_reset, running, state
   );

endinterface

// File: rtl/stopwatch_seconds_ctrl_rise_pulse.sv
// Level-to-edge detector: a registered copy of the level, rise is high
// for the one cycle where the level is high but was low the cycle before.
module rise_pulse #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic level,
   output logic rise
);

   logic level_q;

   // A reset value of 1 masks a level that is already high at reset release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         level_q <= RESET_VAL;
      end else begin
         level_q <= level;
      end
   end

   assign rise = level & ~level_q;

endmodule

// File: rtl/stopwatch_seconds_ctrl.sv
// Stopwatch run control and seconds stage: button FSM, 1 Hz prescaler,
// 0..SEC_MAX seconds counter and pulses to the minutes counter.
module stopwatch_seconds_ctrl #(
   parameter int TICK_DIV = stopwatch_pkg::TICK_DIV_DEFAULT,
   parameter int SEC_MAX  = stopwatch_pkg::SEC_MAX
) (
   input logic                     clk,
   input logic                     rst_n,
   stopwatch_seconds_ctrl_if.slave bus
);

   import stopwatch_pkg::*;

   localparam int              PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0]   PRESC_LAST = PW'(TICK_DIV - 1);
   localparam logic [5:0]      SEC_LAST   = 6'(SEC_MAX);

   logic start_rise;
   logic stop_rise;
   logic reset_rise;

   state_t        state_q;
   state_t        state_d;
   logic [PW-1:0] presc_q;
   logic [PW-1:0] presc_d;
   logic [5:0]    sec_q;
   logic [5:0]    sec_d;
   logic          men_q;
   logic          men_d;
   logic          mrst_q;
   logic          mrst_d;
   logic          run_q;

   rise_pulse #(.RESET_VAL(1'b1)) u_start_rise (
      .clk   (clk),
      .rst_n (rst_n),
      .level (bus.start),
      .rise  (start_rise)
   );

   rise_pulse #(.RESET_VAL(1'b1)) u_stop_rise (
      .clk   (clk),
      .rst_n (rst_n),
      .level (bus.stop),
      .rise  (stop_rise)
   );

   rise_pulse #(.RESET_VAL(1'b1)) u_reset_rise (
      .clk   (clk),
      .rst_n (rst_n),
      .level (bus.reset),
      .rise  (reset_rise)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         presc_q <= '0;
         sec_q   <= '0;
         men_q   <= 1'b0;
         mrst_q  <= 1'b0;
         run_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         presc_q <= presc_d;
         sec_q   <= sec_d;
         men_q   <= men_d;
         mrst_q  <= mrst_d;
         run_q   <= (state_d == RUNNING);
      end
   end

   // Reset edge wins over everything; a stop edge freezes the prescaler so
   // the sub-second phase (even a pending tick) survives pause/resume.
   always_comb begin
      state_d = state_q;
      presc_d = presc_q;
      sec_d   = sec_q;
      men_d   = 1'b0;
      mrst_d  = 1'b0;
      if (reset_rise) begin
         state_d = IDLE;
         presc_d = '0;
         sec_d   = '0;
         mrst_d  = 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               presc_d = '0;
               if (start_rise) begin
                  state_d = RUNNING;
               end
            end
            RUNNING: begin
               if (stop_rise) begin
                  state_d = PAUSED;
               end else if (presc_q == PRESC_LAST) begin
                  presc_d = '0;
                  if (sec_q == SEC_LAST) begin
                     sec_d = '0;
                     men_d = 1'b1;
                  end else begin
                     sec_d = sec_q + 6'd1;
                  end
               end else begin
                  presc_d = presc_q + PW'(1);
               end
            end
            PAUSED: begin
               if (start_rise) begin
                  state_d = RUNNING;
               end
            end
            default: begin
               state_d = IDLE;
               presc_d = '0;
               sec_d   = '0;
            end
         endcase
      end
   end

   assign bus.seconds    = sec_q;
   assign bus.min_enable = men_q;
   assign bus.min_reset  = mrst_q;
   assign bus.running    = run_q;
   assign bus.state      = state_q;

endmodule

// File: doc/stopwatch_seconds_ctrl.md
# stopwatch_seconds_ctrl

Run-control and seconds stage of the digital stopwatch, sitting directly upstream of the minutes counter. Converts start/stop/reset button levels into a three-state run FSM, divides `clk` down to a 1 Hz tick, counts seconds 0–59, and drives the minutes counter's `enable` (one pulse per seconds wrap) and `reset` (one pulse per reset request).

## Interface
- `TICK_DIV`, default 100_000_000: `clk` cycles per second tick. Must be at least 2.
- `SEC_MAX`, default 59: terminal seconds value.
- `clk`  in  1  system clock. Reset `rst_n` is asynchronous and active-low; clock is `clk`.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  start button level, synchronous to `clk`.
- `stop`  in  1  stop button level, synchronous to `clk`.
- `reset`  in  1  clear button level, synchronous to `clk`.
- `seconds`  out  6  current seconds, range 0..SEC_MAX.
- `min_enable`  out  1  one-cycle pulse to the minutes counter `enable`.
- `min_reset`  out  1  one-cycle pulse to the minutes counter `reset`.
- `running`  out  1  high while the state is RUNNING.
- `state`  out  2  FSM state: IDLE=00, RUNNING=01, PAUSED=10.

## Operation
- Edge detect on each button: `rise = in & ~in_q`. The `in_q` registers reset to 1, so a button held through reset release is ignored until it is released and pressed again.
- Priority when edges coincide: reset > stop > start.
- FSM transitions:
  - IDLE: start goes to RUNNING.
  - RUNNING: stop goes to PAUSED; reset goes to IDLE.
  - PAUSED: start goes to RUNNING; reset goes to IDLE.
  - reset in IDLE stays in IDLE.
  - start in RUNNING and stop in IDLE or PAUSED are ignored.
- Prescaler, width `$clog2(TICK_DIV)`:
  - RUNNING: counts 0..TICK_DIV-1, then wraps.
  - PAUSED: holds, so the sub-second phase is kept across pause/resume.
  - IDLE: cleared.
- `tick` = RUNNING, prescaler == TICK_DIV-1, and no stop/reset edge in that cycle.
- On `tick`: if seconds == SEC_MAX, set seconds to 0 and `min_enable` to 1; otherwise seconds + 1.
- Any reset edge, in any state: seconds ← 0, prescaler ← 0, state ← IDLE, `min_reset` ← 1.
- A stop edge coinciding with a terminal prescaler count suppresses the tick. The prescaler holds at TICK_DIV-1, so the tick fires on the first cycle after resume.
- `min_enable` and `min_reset` default to 0 every cycle and are never high together.

## Timing
- All outputs are registered.
- Values after `rst_n` assertion: state IDLE, seconds 0, prescaler 0, `min_enable` 0, `min_reset` 0, `running` 0.
- Button to state: one edge. The edge that samples the rising input updates the state.
- Seconds wrap: `min_enable` is high in the same cycle seconds first reads 0. The minutes counter therefore updates one edge later.
- Seconds period in RUNNING is exactly TICK_DIV cycles. The first tick after IDLE→RUNNING occurs TICK_DIV edges after entry.
- `min_reset` is high in the same cycle seconds reads 0 after a reset edge.
- `rst_n` asserted mid-count clears everything asynchronously. No pulse is emitted.

## Structure
- Shared package `stopwatch_pkg` holds:
  - state encodings IDLE/RUNNING/PAUSED;
  - `SEC_MAX`=59 and `MIN_MAX`=99 constants, shared with the minutes counter;
  - the default `TICK_DIV`.
- One sub-module, `rise_pulse`: a registered level-to-edge detector with a parameterised reset value. Instantiate it three times.
- The FSM, prescaler and seconds counter live in the top module.

## Test plan
All scenarios use TICK_DIV=4.
- Release `rst_n` with all buttons low, then idle 100 cycles → seconds=0, state=00, no `min_enable` or `min_reset` pulses.
- Pulse `start` → state=01 next edge, seconds=1 after 4 more edges. Run 240 cycles → seconds wraps 59→0 with exactly one single-cycle `min_enable`, coincident with seconds=0.
- In RUNNING at seconds=5 with prescaler=2, pulse `stop` → seconds holds 5 for 50 cycles. Pulse `start` → seconds=6 on the 2nd edge after re-entering RUNNING.
- In RUNNING at seconds=30, pulse `reset` → next edge: seconds=0, state=00, `min_reset` high for one cycle, `min_enable` low.
- Raise `reset`, `stop` and `start` in the same cycle while RUNNING → state=00, one `min_reset` pulse, `running`=0.
- Hold `start` high through `rst_n` deassertion → stays IDLE. Release then press `start` → RUNNING.
